// File: rtl/pc_sequencer.sv
// Program-counter unit: PC register, prioritised next-PC selection, EPC capture
// and a circular return-address stack that predicts jr $ra targets.
module pc_sequencer #(
    parameter int             N            = 32,
    parameter logic [N-1:0]   RESET_VECTOR = 32'h0040_0000,
    parameter logic [N-1:0]   EXC_VECTOR   = 32'h8000_0180,
    parameter int             RAS_DEPTH    = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall_i,
    input  logic         exc_i,
    input  logic         eret_i,
    input  logic         branch_taken_i,
    input  logic [N-1:0] branch_target_i,
    input  logic         jump_i,
    input  logic         call_i,
    input  logic         ret_i,
    input  logic [N-1:0] jump_target_i,
    output logic [N-1:0] pc_o,
    output logic [N-1:0] pc_plus4_o,
    output logic [N-1:0] epc_o,
    output logic [N-1:0] ras_top_o,
    output logic         ras_empty_o,
    output logic         ras_full_o,
    output logic         misalign_o,
    output logic         ras_underflow_o
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(RAS_DEPTH);

    logic [N-1:0]  pc_q, pc_d;
    logic [N-1:0]  epc_q, epc_d;
    logic [N-1:0]  ras_mem_q [RAS_DEPTH];
    logic [N-1:0]  ras_mem_d [RAS_DEPTH];
    logic [PW-1:0] ras_ptr_q, ras_ptr_d;
    logic [CW-1:0] ras_count_q, ras_count_d;
    logic          misalign_q, misalign_d;
    logic          underflow_q, underflow_d;

    logic [N-1:0]  pc_plus4;
    logic [N-1:0]  ras_top;
    logic          ras_empty;
    logic          ras_full;
    logic          redirect;
    logic [N-1:0]  target;
    logic          push;
    logic          pop;

    assign pc_plus4  = pc_q + N'(4);
    assign ras_empty = (ras_count_q == '0);
    assign ras_full  = (ras_count_q == CNT_FULL);
    // Top lives just below the write pointer; the pointer wraps modulo the depth.
    assign ras_top   = ras_empty ? '0 : ras_mem_q[ras_ptr_q - PTR_ONE];

    always_comb begin
        pc_d        = pc_plus4;
        epc_d       = epc_q;
        ras_mem_d   = ras_mem_q;
        ras_ptr_d   = ras_ptr_q;
        ras_count_d = ras_count_q;
        misalign_d  = 1'b0;
        underflow_d = 1'b0;
        redirect    = 1'b0;
        target      = '0;
        push        = 1'b0;
        pop         = 1'b0;

        if (exc_i) begin
            pc_d  = EXC_VECTOR;
            epc_d = pc_q;
        end else if (stall_i) begin
            pc_d = pc_q;
        end else begin
            if (eret_i) begin
                redirect = 1'b1;
                target   = epc_q;
            end else if (branch_taken_i) begin
                redirect = 1'b1;
                target   = branch_target_i;
            end else if (jump_i) begin
                redirect = 1'b1;
                target   = jump_target_i;
                push     = call_i;
            end else if (ret_i) begin
                if (ras_empty) begin
                    underflow_d = 1'b1;
                end else begin
                    redirect = 1'b1;
                    target   = ras_top;
                    pop      = 1'b1;
                end
            end

            // A misaligned redirect traps instead and leaves the RAS untouched.
            if (redirect && (target[1:0] != 2'b00)) begin
                pc_d       = EXC_VECTOR;
                epc_d      = pc_q;
                misalign_d = 1'b1;
            end else begin
                if (redirect) begin
                    pc_d = target;
                end
                if (push) begin
                    ras_mem_d[ras_ptr_q] = pc_plus4;
                    ras_ptr_d            = ras_ptr_q + PTR_ONE;
                    if (!ras_full) begin
                        ras_count_d = ras_count_q + CNT_ONE;
                    end
                end else if (pop) begin
                    ras_ptr_d   = ras_ptr_q - PTR_ONE;
                    ras_count_d = ras_count_q - CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q        <= RESET_VECTOR;
            epc_q       <= '0;
            ras_ptr_q   <= '0;
            ras_count_q <= '0;
            misalign_q  <= 1'b0;
            underflow_q <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem_q[i] <= '0;
            end
        end else begin
            pc_q        <= pc_d;
            epc_q       <= epc_d;
            ras_ptr_q   <= ras_ptr_d;
            ras_count_q <= ras_count_d;
            misalign_q  <= misalign_d;
            underflow_q <= underflow_d;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem_q[i] <= ras_mem_d[i];
            end
        end
    end

    assign pc_o            = pc_q;
    assign pc_plus4_o      = pc_plus4;
    assign epc_o           = epc_q;
    assign ras_top_o       = ras_top;
    assign ras_empty_o     = ras_empty;
    assign ras_full_o      = ras_full;
    assign misalign_o      = misalign_q;
    assign ras_underflow_o = underflow_q;

endmodule
